// File: rtl/sweep_pkg.sv
// Shared types and constants for the minterm sweeper: FSM state encoding,
// vector-space sizing and the default golden truth table.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_e;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int ERR_W       = 5;

    localparam logic [NUM_VECTORS-1:0] DEFAULT_EXPECTED_TT = 16'h3F75;

    // A settle time of zero still needs one hold cycle before sampling.
    function automatic int unsigned eff_settle(input int unsigned cycles);
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts clocks while enabled and flags the last settle
// cycle so the sweeper can move to sampling on the following edge.
module settle_timer
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);

    localparam int unsigned EFF_CYCLES = eff_settle(SETTLE_CYCLES);
    localparam int          CNT_W      = (EFF_CYCLES > 1) ? $clog2(EFF_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = (cnt_q == CNT_W'(EFF_CYCLES - 1));

    // NOTE: cnt_d gets a default before any condition so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/minterm_sweeper.sv
// Drives all 16 {A,B,C,D} vectors to a 4-input function block, waits a settle
// time per vector, and captures F into a truth table. Define MISMATCH_CHECK_EN
// to add the golden-table comparison (mismatch, err_cnt, EXPECTED_TT).
module minterm_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 6
`ifdef MISMATCH_CHECK_EN
    ,
    parameter logic [NUM_VECTORS-1:0] EXPECTED_TT = DEFAULT_EXPECTED_TT
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth_tab
`ifdef MISMATCH_CHECK_EN
    ,
    output logic                   mismatch,
    output logic [ERR_W-1:0]       err_cnt
`endif
);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NUM_VECTORS-1:0] tt_q;

    logic accept;
    logic last_vec;
    logic settle_done;

    assign accept   = (state_q == IDLE) && start;
    assign last_vec = (idx_q == IDX_W'(NUM_VECTORS - 1));

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != SETTLE),
        .expire (settle_done)
    );

    // The vector index is itself the registered drive to the function block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
        end else begin
            // NOTE: done_q defaults low each edge; the later <= in SAMPLE wins, so done is a one-cycle pulse.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= '0;
                        tt_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt_q[idx_q] <= f_in;
                    if (last_vec) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth_tab    = tt_q;

`ifdef MISMATCH_CHECK_EN
    logic                   err_hit;
    logic [ERR_W-1:0]       err_cnt_q;
    logic [ERR_W-1:0]       err_sum;
    logic                   mismatch_q;

    // err_sum includes the vector being sampled so mismatch sees the final count.
    assign err_hit = (state_q == SAMPLE) && (f_in != EXPECTED_TT[idx_q]);
    assign err_sum = err_cnt_q + ERR_W'(err_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
        end else if (accept) begin
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
        end else if (state_q == SAMPLE) begin
            err_cnt_q <= err_sum;
            if (last_vec) begin
                mismatch_q <= (err_sum != '0);
            end
        end
    end

    assign err_cnt  = err_cnt_q;
    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_minterm_sweeper.sv
// Self-checking bench for minterm_sweeper: table-driven and random sweeps
// against a function-block model that returns wrong F until inputs have settled.
module tb_minterm_sweeper;

    localparam int S       = 6;
    localparam int VEC_CYC = S + 1;
    localparam int SWEEP   = 16 * VEC_CYC;
    localparam logic [15:0] GOLDEN = 16'h3F75;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        a, b, c, d;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] truth_tab;
`ifdef MISMATCH_CHECK_EN
    logic        mismatch;
    logic [4:0]  err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] func_tt = GOLDEN;
    bit          stuck   = 1'b0;
    int          held    = 0;
    logic [3:0]  prev_v  = 4'h0;

    always #5 clk = ~clk;

    minterm_sweeper #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .f_in      (f_in),
        .busy      (busy),
        .done      (done),
        .truth_tab (truth_tab)
`ifdef MISMATCH_CHECK_EN
        ,
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
`endif
    );

    // Function block model: F is only correct once the vector has been held
    // for SETTLE+1 full clocks (the cycle it is sampled on); before that it is inverted.
    always @(negedge clk) begin
        logic [3:0] v;
        v = {a, b, c, d};
        if (v !== prev_v) held = 1;
        else held = held + 1;
        prev_v = v;
        if (stuck) f_in = 1'b1;
        else if (held >= VEC_CYC) f_in = func_tt[v];
        else f_in = ~func_tt[v];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); returns at the
    // negedge of the done cycle. Cycle 0 is the cycle in which start is driven.
    task automatic run_sweep(input string tag, input logic [15:0] fn, input bit stuck_i,
                             input bit extra, input logic [15:0] exp_tt);
        int k, done_at, vec_bad, busy_cnt, ev;
        func_tt = fn;
        stuck   = stuck_i;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        done_at  = 0;
        vec_bad  = 0;
        busy_cnt = 0;
        check({tag, "_tt_cleared"}, truth_tab, 32'h0);
        while (k <= 2 * SWEEP) begin
            ev = (k - 1) / VEC_CYC;
            if (ev > 15) ev = 15;
            if ({a, b, c, d} !== 4'(ev)) vec_bad++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            start = extra && (k == 10 || k == 50);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_at, SWEEP + 1);
        check({tag, "_busy_cycles"}, busy_cnt, SWEEP);
        check({tag, "_vector_order_errs"}, vec_bad, 0);
        check({tag, "_truth_tab"}, truth_tab, exp_tt);
`ifdef MISMATCH_CHECK_EN
        check({tag, "_err_cnt"}, err_cnt, $countones(exp_tt ^ GOLDEN));
        check({tag, "_mismatch"}, mismatch, (exp_tt != GOLDEN));
`endif
    endtask

    task automatic check_hold(input string tag, input logic [15:0] exp_tt);
        @(negedge clk);
        check({tag, "_done_width"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
        repeat (5) @(negedge clk);
        check({tag, "_vec_hold"}, {a, b, c, d}, 4'hF);
        check({tag, "_tt_hold"}, truth_tab, exp_tt);
    endtask

    typedef struct {
        string       name;
        logic [15:0] fn;
        bit          stuck;
        bit          extra;
        logic [15:0] exp_tt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n, done_hits, busy_hits;
        logic [15:0] rfn;

        tbl[0] = '{"golden",   16'h3F75, 1'b0, 1'b0, 16'h3F75};
        tbl[1] = '{"zeros",    16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[2] = '{"ones",     16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
        tbl[3] = '{"a5a5",     16'hA5A5, 1'b0, 1'b1, 16'hA5A5};
        tbl[4] = '{"stuck1",   16'h3F75, 1'b1, 1'b0, 16'hFFFF};
        tbl[5] = '{"edge8001", 16'h8001, 1'b0, 1'b0, 16'h8001};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_vec", {a, b, c, d}, 4'h0);
        check("reset_tt", truth_tab, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven sweeps; "extra" pulses start at cycles 10 and 50 while busy.
        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].name, tbl[i].fn, tbl[i].stuck, tbl[i].extra, tbl[i].exp_tt);
            check_hold(tbl[i].name, tbl[i].exp_tt);
        end

        // Back-to-back: start asserted in the done cycle of the first sweep.
        run_sweep("b2b_first", 16'h1234, 1'b0, 1'b0, 16'h1234);
        run_sweep("b2b_second", 16'hC3A9, 1'b0, 1'b0, 16'hC3A9);
        check_hold("b2b_second", 16'hC3A9);

        // Reset mid-sweep at vector 7, held for 3 clocks.
        func_tt = GOLDEN;
        stuck   = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({a, b, c, d} !== 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_idx7", {a, b, c, d}, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_vec", {a, b, c, d}, 4'h0);
        check("midrst_tt", truth_tab, 32'h0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        done_hits = 0;
        busy_hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (done !== 1'b0) done_hits++;
            if (busy !== 1'b0) busy_hits++;
        end
        check("midrst_no_done", done_hits, 0);
        check("midrst_no_busy", busy_hits, 0);

        // Random function blocks checked against the model table itself.
        for (int i = 0; i < 4; i++) begin
            rfn = 16'($urandom);
            run_sweep($sformatf("rand%0d", i), rfn, 1'b0, 1'($urandom_range(0, 1)), rfn);
            check_hold($sformatf("rand%0d", i), rfn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
